// File: rtl/slice_add_pkg.sv
// Shared types and sizing for the slice-serial adder.
// Imported by the sequencer top and its 4-bit slice adder.
package slice_add_pkg;

  localparam int WIDTH   = 16;
  localparam int SLICE   = 4;
  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNTW    = $clog2(NSLICES);

  localparam logic [CNTW-1:0] LAST_SLICE =
    CNTW'(NSLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  function automatic int slice_base(
    input logic [CNTW-1:0] k
  );
    return int'(k) * SLICE;
  endfunction

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple adder, reused once per cycle.
// The sequencer feeds it one operand slice at a time.
module add4_slice
  import slice_add_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  always_comb begin
    c[0] = cin;
    s    = '0;
    for (int i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE];
  end

endmodule

// File: rtl/slice_add_sequencer.sv
// Adds A+B one 4-bit slice per cycle through a single slice adder.
// Sum/CO update atomically when the last slice completes.
module slice_add_sequencer
  import slice_add_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done
);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_nx;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;
  logic             carry_q;
  logic [CNTW-1:0]  cnt_q;
  logic             run_prev;
  logic             busy_q;
  logic             done_q;

  logic             start;
  logic             last;
  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;
  int               base;

  assign start = Run & ~run_prev;
  assign last  = (cnt_q == LAST_SLICE);

  always_comb begin
    base = slice_base(cnt_q);
    sl_a = a_q[base +: SLICE];
    sl_b = b_q[base +: SLICE];
  end

  add4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_co)
  );

  always_comb begin
    work_nx = work_q;
    work_nx[base +: SLICE] = sl_s;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last)  state_nx = DONE;
      DONE:    if (!Run)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // run_prev resets high so a held Run cannot start an add
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      sum_q    <= '0;
      co_q     <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      run_prev <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      run_prev <= Run;
      busy_q   <= (state_nx == ADD);
      done_q   <= (state_nx == DONE);
      if (LoadB && state != ADD) b_q <= SW;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= SW;
            cnt_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        ADD: begin
          work_q  <= work_nx;
          carry_q <= sl_co;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            sum_q <= work_nx;
            co_q  <= sl_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum  = sum_q;
  assign CO   = co_q;
  assign Bval = b_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_slice_add_sequencer.sv
// Bench for slice_add_sequencer: vector table plus corner sequences.
// Expected results are queued at start and popped at Done.
module tb_slice_add_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LoadB;
  logic        Run;
  logic [15:0] SW;
  logic [15:0] Sum;
  logic        CO;
  logic [15:0] Bval;
  logic        Busy;
  logic        Done;

  slice_add_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .LoadB (LoadB),
    .Run   (Run),
    .SW    (SW),
    .Sum   (Sum),
    .CO    (CO),
    .Bval  (Bval),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] b;
    logic [15:0] a;
    logic [15:0] sum;
    logic        co;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic [15:0] bv;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_sum = 16'h0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_b(input logic [15:0] v);
    SW    = v;
    LoadB = 1'b1;
    step();
    LoadB = 1'b0;
    check("bval_load", Bval, v);
  endtask

  task automatic start_add(input logic [15:0] a,
                           input logic [15:0] es,
                           input logic        eco,
                           input logic [15:0] eb,
                           input logic        ld);
    exp_t e;
    e.sum = es;
    e.co  = eco;
    e.bv  = eb;
    sb.push_back(e);
    SW    = a;
    Run   = 1'b1;
    LoadB = ld;
    step();
    LoadB = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (Busy && n < 16) begin
      check("sum_hold", Sum, last_sum);
      check("done_low", Done, 1'b0);
      n++;
      step();
    end
    check("busy_len", n, 4);
    check("done_high", Done, 1'b1);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty expected entry");
    end else begin
      e = sb.pop_front();
      check("sum", Sum, e.sum);
      check("co", CO, e.co);
      check("bval", Bval, e.bv);
      last_sum = e.sum;
    end
  endtask

  task automatic release_run(input int hold);
    for (int i = 0; i < hold; i++) begin
      step();
      check("done_hold", Done, 1'b1);
      check("no_retrig", Busy, 1'b0);
    end
    Run = 1'b0;
    step();
    check("idle_done", Done, 1'b0);
    check("idle_busy", Busy, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h0002, 16'h0001, 16'h0003, 1'b0};
    vecs[1] = '{16'h0001, 16'hFFFF, 16'h0000, 1'b1};
    vecs[2] = '{16'h0001, 16'h0FFF, 16'h1000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};

    Reset = 1'b1;
    LoadB = 1'b0;
    Run   = 1'b1;
    SW    = 16'hABCD;
    step();
    step();
    check("rst_sum", Sum, 16'h0);
    check("rst_co", CO, 1'b0);
    check("rst_bval", Bval, 16'h0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);

    // Run held high across reset release must not start
    Reset = 1'b0;
    step();
    step();
    check("no_start_rst", Busy, 1'b0);
    Run = 1'b0;
    step();

    foreach (vecs[i]) begin
      load_b(vecs[i].b);
      start_add(vecs[i].a, vecs[i].sum, vecs[i].co,
                vecs[i].b, 1'b0);
      wait_busy();
      pop_check();
      release_run(0);
    end

    // LoadB ignored during ADD, honoured in DONE
    load_b(16'h0005);
    start_add(16'h0010, 16'h0015, 1'b0, 16'h0005, 1'b0);
    LoadB = 1'b1;
    SW    = 16'h1234;
    wait_busy();
    pop_check();
    step();
    check("bval_done_load", Bval, 16'h1234);
    check("done_after_load", Done, 1'b1);
    LoadB = 1'b0;
    release_run(0);

    // LoadB and start together: add uses the new B
    start_add(16'h0003, 16'h0006, 1'b0, 16'h0003, 1'b1);
    wait_busy();
    pop_check();
    release_run(10);

    // Reset on second ADD cycle aborts the add
    load_b(16'h0001);
    SW  = 16'h0002;
    Run = 1'b1;
    step();
    check("abort_busy1", Busy, 1'b1);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    last_sum = 16'h0;
    check("abort_sum", Sum, 16'h0);
    check("abort_co", CO, 1'b0);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    step();
    step();
    step();
    check("abort_nostart", Busy, 1'b0);
    Run = 1'b0;
    step();
    start_add(16'h0007, 16'h0007, 1'b0, 16'h0000, 1'b0);
    wait_busy();
    pop_check();
    release_run(2);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_add_sequencer.md
SLICE_ADD_SEQUENCER -- requirements
Module: slice_add_sequencer

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 LoadB  input  1  active-high load request for operand B (conditioned button level).
REQ-004 Run  input  1  active-high run request (level); start on rising edge only.
REQ-005 SW  input  16  operand source for A (on start) and B (on load).
REQ-006 Sum  output  16  registered result; holds previous result until new add completes.
REQ-007 CO  output  1  registered carry-out of last completed add.
REQ-008 Bval  output  16  registered operand B, for hex display.
REQ-009 Busy  output  1  registered; 1 while state ADD.
REQ-010 Done  output  1  registered; 1 while state DONE.

Function
REQ-011 FSM states SHALL be IDLE, ADD, DONE.
REQ-012 Start condition SHALL be Run=1 sampled with run_prev=0; run_prev is Run registered every cycle.
REQ-013 IDLE + start: A<=SW, slice counter<=0, working carry<=0, state->ADD.
REQ-014 ADD: slice k (counter value, 0..3): work[4k+3:4k] <= A[4k+3:4k]+B[4k+3:4k]+carry; carry<=slice carry-out; counter++.
REQ-015 ADD with counter=3: after that slice, Sum<=complete work value, CO<=final carry, state->DONE, same edge.
REQ-016 Latency: Busy=1 for exactly 4 cycles; Done=1 on 4th edge after the edge that sampled start.
REQ-017 Sum and CO SHALL change only on the ADD->DONE transition (atomic update, no partial results visible).
REQ-018 DONE: hold Done=1 while Run=1; Run=0 -> IDLE next edge; Done=0 in IDLE.
REQ-019 Run held high through DONE SHALL NOT retrigger; a new add requires Run low then high.
REQ-020 LoadB=1 in IDLE or DONE: B<=SW next edge; Bval follows B.
REQ-021 LoadB during ADD SHALL be ignored (B stable for whole add).
REQ-022 Run edges during ADD SHALL be ignored; state counter not restarted.
REQ-023 LoadB and start in same IDLE cycle: B<=SW and A<=SW both; add uses the new B (B update precedes first slice).
REQ-024 Carry wrap: 16-bit result modulo 2^16, overflow reported only via CO.

Reset
REQ-025 Reset=1 at an edge: state IDLE; A, B, work, Sum=0; CO, carry, counter, Busy, Done=0.
REQ-026 run_prev SHALL reset to 1, so Run held high across reset release does not start an add.
REQ-027 Reset mid-ADD SHALL abort; Sum/CO return to 0, no partial result retained.
REQ-028 Reset has priority over LoadB and Run in the same cycle.

Structure
REQ-029 Shared package slice_add_pkg: state enum (IDLE, ADD, DONE), WIDTH=16, SLICE=4, NSLICES=4.
REQ-030 One sub-module add4_slice: combinational 4-bit ripple adder (a, b, cin -> s, cout), single instance reused across cycles.
REQ-031 All outputs driven directly from registers; no combinational output paths.

Verification
REQ-032 Reset; LoadB with SW=0x0002; Run pulse with SW=0x0001 -> Busy 4 cycles, then Sum=0x0003, CO=0, Bval=0x0002, Done=1.
REQ-033 B=0x0001, A=0xFFFF -> Sum=0x0000, CO=1 after 4 cycles.
REQ-034 B=0x0001, A=0x0FFF -> Sum=0x1000, CO=0 (carry through slices 0-2); Sum stays at prior value until Done.
REQ-035 LoadB with SW=0x1234 during ADD -> Bval unchanged, result uses old B; same LoadB in DONE -> Bval=0x1234.
REQ-036 Reset asserted on 2nd ADD cycle -> next cycle IDLE, Sum=0, CO=0, Busy=0; Run held high after release -> no start until Run drops and rises.
REQ-037 Run held high 10 cycles after start -> exactly one add, Done held, IDLE one cycle after Run=0.
